axi_lite_arbiter_2to1: RTL and testbench
========================================

# axi_lite_arbiter_2to1

Two-master, one-slave AXI-Lite arbiter that shares a single memory-side slave port (the RAM/ROM AXI-Lite slave interface) between the instruction-fetch master (M0) and the load/store master (M1). Exactly one transaction is outstanding at a time. The grant is held from address acceptance until the matching response handshake completes. The block sits between the core's bus masters and the slave interface in the SoC interconnect.

## Interface
Parameters:
- ADDR_W, 64, address width (matches `AddrBus`)
- DATA_W, 64, data width (matches `DataBus`)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low; clock ACLK
- Mx_AWVALID/AWADDR/AWPROT (x=0,1)  in  1/ADDR_W/3  master write-address request
- Mx_AWREADY  out  1  write-address accept to master x
- Mx_WVALID/WDATA/WSTRB  in  1/DATA_W/4  master write data
- Mx_WREADY  out  1  write-data accept to master x
- Mx_BVALID/BRESP  out  1/3  write response to master x
- Mx_BREADY  in  1  master x response accept
- Mx_ARVALID/ARADDR/ARPROT  in  1/ADDR_W/3  master read-address request
- Mx_ARREADY  out  1  read-address accept to master x
- Mx_RVALID/RDATA/RRESP  out  1/DATA_W/3  read data to master x
- Mx_RREADY  in  1  master x read-data accept
- S_AW*/S_W*/S_AR*/S_BREADY/S_RREADY  out  same widths  slave-side request channels
- S_AWREADY/S_WREADY/S_ARREADY/S_BVALID/S_BRESP/S_RVALID/S_RDATA/S_RRESP  in  same widths  slave-side responses
- GrantOut  out  2  one-hot current owner (2'b01 = M0, 2'b10 = M1, 0 = none)

## Operation
- FSM states are IDLE, RADDR, RDATA, WRITE and WRESP.
- IDLE: sample requests. Master x requests if Mx_AWVALID or Mx_ARVALID. Pick the winner per the arbitration policy (Configuration) and register the grant.
  - Within the winning master, a write (AWVALID) takes precedence over a read (ARVALID).
  - Next state is WRITE or RADDR. With no request, stay in IDLE.
- RADDR: S_AR* = granted Mx_AR*; Mx_ARREADY = S_ARREADY. On the AR handshake, go to RDATA.
- RDATA: Mx_RVALID/RDATA/RRESP = S_R*; S_RREADY = Mx_RREADY. On the R handshake, go to IDLE and release the grant.
- WRITE: S_AW* and S_W* are forwarded independently from the granted master. Internal flags aw_done and w_done set on their respective handshakes; each channel's VALID is masked to 0 once its flag is set. When both flags are set (either order, or the same cycle), go to WRESP and clear the flags.
- WRESP: Mx_BVALID/BRESP = S_B*; S_BREADY = Mx_BREADY. On the B handshake, go to IDLE.
- Non-granted master: all its READY/VALID outputs are 0 and its data outputs are 0.
- In any state where a channel is not active, slave-side VALIDs and READYs are 0 and slave-side data is 0.
- Routing is combinational from the registered grant and state. No data is stored in the block.

## Timing
- Reset values (reset applied at edge N, effective N+1):
  - state = IDLE, grant = 0, GrantOut = 0, aw_done = w_done = 0, last-winner = M1.
  - Every output VALID/READY = 0; every data/resp output = 0.
- Arbitration latency: a request first seen in IDLE at edge N drives S_ARVALID/S_AWVALID from cycle N+1.
- Minimum read occupancy is 3 cycles (IDLE, RADDR, RDATA). There is always one IDLE cycle between consecutive grants.
- A master's request that is still valid while it is not granted waits without a READY. Masters must hold VALID stable (AXI rule); the block does not check this.
- Simultaneous M0 and M1 requests in IDLE are resolved by the policy. The loser is served in the next grant.
- Reset mid-transaction drops the in-flight transaction: no response is returned and all outputs take their reset values.
- Slave stalls (READY or VALID held low) are unbounded. The grant is never pre-empted.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin. On a tie, the master that is not the last winner is granted.
  - The last-winner register updates on every grant.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, M1 (load/store) always beats M0.
  - The last-winner register is not implemented.

## Test plan
- Single read: M0 ARADDR=0x8000_0000; slave ARREADY after 2 cycles, then RDATA=0x1122334455667788 → M0 receives that RDATA with RRESP passed through. GrantOut = 01 from RADDR through RDATA, then 00.
- Write with W before AW: M1 WDATA=0xDEAD_BEEF, WSTRB=4'hF at cycle 1; AWADDR=0x10 at cycle 3 → S_WVALID drops after its handshake and WRESP is entered only after AW completes. M1 gets BVALID with S_BRESP (3'b111).
- Same-cycle contention: both M0 and M1 ARVALID in IDLE → M1 is served first. Then:
  - With ARB_ROUND_ROBIN_EN: when both re-request, M0 is served next.
  - Without ARB_ROUND_ROBIN_EN: M1 wins every tie.
- Write-over-read precedence: M0 asserts AWVALID and ARVALID together → the write completes (B handshake) before S_ARVALID is asserted.
- Backpressure: hold M1_RREADY=0 for 5 cycles while S_RVALID=1 → the grant is held and M0 requests get no ARREADY. Release → IDLE for one cycle, then M0 is granted.
- Reset mid-op: assert ARESETn=0 in the RDATA state → next cycle all outputs are 0, state is IDLE, GrantOut = 0, and no RVALID reaches the master.

Source files
------------

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master, one-slave AXI-Lite arbiter; one outstanding transaction, grant held until the response.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin; otherwise M1 has fixed priority over M0.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0 (instruction fetch)
  input  logic              M0_AWVALID,
  input  logic [ADDR_W-1:0] M0_AWADDR,
  input  logic [2:0]        M0_AWPROT,
  output logic              M0_AWREADY,
  input  logic              M0_WVALID,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic [3:0]        M0_WSTRB,
  output logic              M0_WREADY,
  output logic              M0_BVALID,
  output logic [2:0]        M0_BRESP,
  input  logic              M0_BREADY,
  input  logic              M0_ARVALID,
  input  logic [ADDR_W-1:0] M0_ARADDR,
  input  logic [2:0]        M0_ARPROT,
  output logic              M0_ARREADY,
  output logic              M0_RVALID,
  output logic [DATA_W-1:0] M0_RDATA,
  output logic [2:0]        M0_RRESP,
  input  logic              M0_RREADY,
  // master 1 (load/store)
  input  logic              M1_AWVALID,
  input  logic [ADDR_W-1:0] M1_AWADDR,
  input  logic [2:0]        M1_AWPROT,
  output logic              M1_AWREADY,
  input  logic              M1_WVALID,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic [3:0]        M1_WSTRB,
  output logic              M1_WREADY,
  output logic              M1_BVALID,
  output logic [2:0]        M1_BRESP,
  input  logic              M1_BREADY,
  input  logic              M1_ARVALID,
  input  logic [ADDR_W-1:0] M1_ARADDR,
  input  logic [2:0]        M1_ARPROT,
  output logic              M1_ARREADY,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [2:0]        M1_RRESP,
  input  logic              M1_RREADY,
  // shared slave port
  output logic              S_AWVALID,
  output logic [ADDR_W-1:0] S_AWADDR,
  output logic [2:0]        S_AWPROT,
  input  logic              S_AWREADY,
  output logic              S_WVALID,
  output logic [DATA_W-1:0] S_WDATA,
  output logic [3:0]        S_WSTRB,
  input  logic              S_WREADY,
  input  logic              S_BVALID,
  input  logic [2:0]        S_BRESP,
  output logic              S_BREADY,
  output logic              S_ARVALID,
  output logic [ADDR_W-1:0] S_ARADDR,
  output logic [2:0]        S_ARPROT,
  input  logic              S_ARREADY,
  input  logic              S_RVALID,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic [2:0]        S_RRESP,
  output logic              S_RREADY,
  output logic [1:0]        GrantOut
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t      state_r, state_nx;
  logic [1:0]  grant_r, grant_nx;
  logic        aw_done_r, aw_done_nx;
  logic        w_done_r, w_done_nx;
  logic        req0_s, req1_s, win1_s;
  logic        aw_hs_s, w_hs_s;

  // requests of the currently granted master
  logic              sel_s;
  logic              sel_awvalid_s, sel_wvalid_s, sel_bready_s, sel_arvalid_s, sel_rready_s;
  logic [ADDR_W-1:0] sel_awaddr_s, sel_araddr_s;
  logic [2:0]        sel_awprot_s, sel_arprot_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [3:0]        sel_wstrb_s;

  // responses toward the granted master before demux
  logic              g_awready_s, g_wready_s, g_bvalid_s, g_arready_s, g_rvalid_s;
  logic [2:0]        g_bresp_s, g_rresp_s;
  logic [DATA_W-1:0] g_rdata_s;

  assign sel_s         = grant_r[1];
  assign sel_awvalid_s = sel_s ? M1_AWVALID : M0_AWVALID;
  assign sel_awaddr_s  = sel_s ? M1_AWADDR  : M0_AWADDR;
  assign sel_awprot_s  = sel_s ? M1_AWPROT  : M0_AWPROT;
  assign sel_wvalid_s  = sel_s ? M1_WVALID  : M0_WVALID;
  assign sel_wdata_s   = sel_s ? M1_WDATA   : M0_WDATA;
  assign sel_wstrb_s   = sel_s ? M1_WSTRB   : M0_WSTRB;
  assign sel_bready_s  = sel_s ? M1_BREADY  : M0_BREADY;
  assign sel_arvalid_s = sel_s ? M1_ARVALID : M0_ARVALID;
  assign sel_araddr_s  = sel_s ? M1_ARADDR  : M0_ARADDR;
  assign sel_arprot_s  = sel_s ? M1_ARPROT  : M0_ARPROT;
  assign sel_rready_s  = sel_s ? M1_RREADY  : M0_RREADY;

  assign req0_s  = M0_AWVALID | M0_ARVALID;
  assign req1_s  = M1_AWVALID | M1_ARVALID;
  assign aw_hs_s = sel_awvalid_s & ~aw_done_r & S_AWREADY;
  assign w_hs_s  = sel_wvalid_s & ~w_done_r & S_WREADY;

`ifdef ARB_ROUND_ROBIN_EN
  // last_winner_r = 1 means M1 won the previous grant
  logic last_winner_r, last_winner_nx;

  // tie goes to whichever master did not win last time
  always_comb begin
    if (req0_s && req1_s) begin
      win1_s = ~last_winner_r;
    end else begin
      win1_s = req1_s;
    end
  end

  // last-winner register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      last_winner_r <= 1'b1;
    end else begin
      last_winner_r <= last_winner_nx;
    end
  end
`else
  assign win1_s = req1_s;
`endif

  // state, grant and write-completion flags
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_r   <= IDLE;
      grant_r   <= 2'b00;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      state_r   <= state_nx;
      grant_r   <= grant_nx;
      aw_done_r <= aw_done_nx;
      w_done_r  <= w_done_nx;
    end
  end

  // next-state and grant selection
  always_comb begin
    state_nx   = state_r;
    grant_nx   = grant_r;
    aw_done_nx = aw_done_r;
    w_done_nx  = w_done_r;
`ifdef ARB_ROUND_ROBIN_EN
    last_winner_nx = last_winner_r;
`endif
    case (state_r)
      IDLE: begin
        if (req0_s || req1_s) begin
          grant_nx = win1_s ? 2'b10 : 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
          last_winner_nx = win1_s;
`endif
          // write wins over read within the chosen master
          if (win1_s ? M1_AWVALID : M0_AWVALID) begin
            state_nx = WRITE;
          end else begin
            state_nx = RADDR;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      RADDR: begin
        if (sel_arvalid_s && S_ARREADY) begin
          state_nx = RDATA;
        end else begin
          state_nx = RADDR;
        end
      end
      RDATA: begin
        if (S_RVALID && sel_rready_s) begin
          state_nx = IDLE;
          grant_nx = 2'b00;
        end else begin
          state_nx = RDATA;
        end
      end
      WRITE: begin
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_nx   = WRESP;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
        end else begin
          aw_done_nx = aw_done_r | aw_hs_s;
          w_done_nx  = w_done_r | w_hs_s;
        end
      end
      WRESP: begin
        if (S_BVALID && sel_bready_s) begin
          state_nx = IDLE;
          grant_nx = 2'b00;
        end else begin
          state_nx = WRESP;
        end
      end
      default: begin
        state_nx   = IDLE;
        grant_nx   = 2'b00;
        aw_done_nx = 1'b0;
        w_done_nx  = 1'b0;
      end
    endcase
  end

  // channel routing for the active state; everything idle is driven to zero
  always_comb begin
    S_AWVALID   = 1'b0;
    S_AWADDR    = {ADDR_W{1'b0}};
    S_AWPROT    = 3'b000;
    S_WVALID    = 1'b0;
    S_WDATA     = {DATA_W{1'b0}};
    S_WSTRB     = 4'h0;
    S_BREADY    = 1'b0;
    S_ARVALID   = 1'b0;
    S_ARADDR    = {ADDR_W{1'b0}};
    S_ARPROT    = 3'b000;
    S_RREADY    = 1'b0;
    g_awready_s = 1'b0;
    g_wready_s  = 1'b0;
    g_bvalid_s  = 1'b0;
    g_bresp_s   = 3'b000;
    g_arready_s = 1'b0;
    g_rvalid_s  = 1'b0;
    g_rdata_s   = {DATA_W{1'b0}};
    g_rresp_s   = 3'b000;
    case (state_r)
      RADDR: begin
        S_ARVALID   = sel_arvalid_s;
        S_ARADDR    = sel_araddr_s;
        S_ARPROT    = sel_arprot_s;
        g_arready_s = S_ARREADY;
      end
      RDATA: begin
        S_RREADY   = sel_rready_s;
        g_rvalid_s = S_RVALID;
        g_rdata_s  = S_RDATA;
        g_rresp_s  = S_RRESP;
      end
      WRITE: begin
        S_AWVALID   = sel_awvalid_s & ~aw_done_r;
        S_AWADDR    = sel_awaddr_s;
        S_AWPROT    = sel_awprot_s;
        g_awready_s = S_AWREADY & ~aw_done_r;
        S_WVALID    = sel_wvalid_s & ~w_done_r;
        S_WDATA     = sel_wdata_s;
        S_WSTRB     = sel_wstrb_s;
        g_wready_s  = S_WREADY & ~w_done_r;
      end
      WRESP: begin
        S_BREADY   = sel_bready_s;
        g_bvalid_s = S_BVALID;
        g_bresp_s  = S_BRESP;
      end
      default: begin
        S_AWVALID = 1'b0;
      end
    endcase
  end

  assign M0_AWREADY = g_awready_s & grant_r[0];
  assign M0_WREADY  = g_wready_s  & grant_r[0];
  assign M0_BVALID  = g_bvalid_s  & grant_r[0];
  assign M0_BRESP   = grant_r[0] ? g_bresp_s : 3'b000;
  assign M0_ARREADY = g_arready_s & grant_r[0];
  assign M0_RVALID  = g_rvalid_s  & grant_r[0];
  assign M0_RDATA   = grant_r[0] ? g_rdata_s : {DATA_W{1'b0}};
  assign M0_RRESP   = grant_r[0] ? g_rresp_s : 3'b000;

  assign M1_AWREADY = g_awready_s & grant_r[1];
  assign M1_WREADY  = g_wready_s  & grant_r[1];
  assign M1_BVALID  = g_bvalid_s  & grant_r[1];
  assign M1_BRESP   = grant_r[1] ? g_bresp_s : 3'b000;
  assign M1_ARREADY = g_arready_s & grant_r[1];
  assign M1_RVALID  = g_rvalid_s  & grant_r[1];
  assign M1_RDATA   = grant_r[1] ? g_rdata_s : {DATA_W{1'b0}};
  assign M1_RRESP   = grant_r[1] ? g_rresp_s : 3'b000;

  assign GrantOut = grant_r;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed self-checking bench for axi_lite_arbiter_2to1; the slave side is driven by hand.
module tb_axi_lite_arbiter_2to1;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic              M0_AWVALID, M0_WVALID, M0_BREADY, M0_ARVALID, M0_RREADY;
  logic [ADDR_W-1:0] M0_AWADDR, M0_ARADDR;
  logic [2:0]        M0_AWPROT, M0_ARPROT;
  logic [DATA_W-1:0] M0_WDATA;
  logic [3:0]        M0_WSTRB;
  logic              M0_AWREADY, M0_WREADY, M0_BVALID, M0_ARREADY, M0_RVALID;
  logic [2:0]        M0_BRESP, M0_RRESP;
  logic [DATA_W-1:0] M0_RDATA;
  logic              M1_AWVALID, M1_WVALID, M1_BREADY, M1_ARVALID, M1_RREADY;
  logic [ADDR_W-1:0] M1_AWADDR, M1_ARADDR;
  logic [2:0]        M1_AWPROT, M1_ARPROT;
  logic [DATA_W-1:0] M1_WDATA;
  logic [3:0]        M1_WSTRB;
  logic              M1_AWREADY, M1_WREADY, M1_BVALID, M1_ARREADY, M1_RVALID;
  logic [2:0]        M1_BRESP, M1_RRESP;
  logic [DATA_W-1:0] M1_RDATA;
  logic              S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY;
  logic [ADDR_W-1:0] S_AWADDR, S_ARADDR;
  logic [2:0]        S_AWPROT, S_ARPROT;
  logic [DATA_W-1:0] S_WDATA;
  logic [3:0]        S_WSTRB;
  logic              S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
  logic [2:0]        S_BRESP, S_RRESP;
  logic [DATA_W-1:0] S_RDATA;
  logic [1:0]        GrantOut;

  int checks = 0;
  int errors = 0;
  logic [1:0] tie2_exp;

  always #5 ACLK = ~ACLK;

  axi_lite_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_AWVALID(M0_AWVALID), .M0_AWADDR(M0_AWADDR), .M0_AWPROT(M0_AWPROT), .M0_AWREADY(M0_AWREADY),
    .M0_WVALID(M0_WVALID), .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WREADY(M0_WREADY),
    .M0_BVALID(M0_BVALID), .M0_BRESP(M0_BRESP), .M0_BREADY(M0_BREADY),
    .M0_ARVALID(M0_ARVALID), .M0_ARADDR(M0_ARADDR), .M0_ARPROT(M0_ARPROT), .M0_ARREADY(M0_ARREADY),
    .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RREADY(M0_RREADY),
    .M1_AWVALID(M1_AWVALID), .M1_AWADDR(M1_AWADDR), .M1_AWPROT(M1_AWPROT), .M1_AWREADY(M1_AWREADY),
    .M1_WVALID(M1_WVALID), .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WREADY(M1_WREADY),
    .M1_BVALID(M1_BVALID), .M1_BRESP(M1_BRESP), .M1_BREADY(M1_BREADY),
    .M1_ARVALID(M1_ARVALID), .M1_ARADDR(M1_ARADDR), .M1_ARPROT(M1_ARPROT), .M1_ARREADY(M1_ARREADY),
    .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RREADY(M1_RREADY),
    .S_AWVALID(S_AWVALID), .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWREADY(S_AWREADY),
    .S_WVALID(S_WVALID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .S_BREADY(S_BREADY),
    .S_ARVALID(S_ARVALID), .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARREADY(S_ARREADY),
    .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RREADY(S_RREADY),
    .GrantOut(GrantOut)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // inputs change 2 time units after the edge; checks follow 1 unit later
  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // complete a read already in RADDR for master m, then return to IDLE
  task automatic finish_read(input int m);
    S_ARREADY = 1'b1;
    tick();
    S_ARREADY = 1'b0;
    if (m == 1) M1_ARVALID = 1'b0; else M0_ARVALID = 1'b0;
    S_RVALID = 1'b1; S_RDATA = 64'h0; S_RRESP = 3'b000;
    M0_RREADY = 1'b1; M1_RREADY = 1'b1;
    tick();
    S_RVALID = 1'b0; M0_RREADY = 1'b0; M1_RREADY = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0;
    {M0_AWVALID, M0_WVALID, M0_BREADY, M0_ARVALID, M0_RREADY} = 5'b0;
    {M1_AWVALID, M1_WVALID, M1_BREADY, M1_ARVALID, M1_RREADY} = 5'b0;
    M0_AWADDR = 64'h0; M0_ARADDR = 64'h0; M0_AWPROT = 3'b000; M0_ARPROT = 3'b000;
    M0_WDATA = 64'h0; M0_WSTRB = 4'h0;
    M1_AWADDR = 64'h0; M1_ARADDR = 64'h0; M1_AWPROT = 3'b000; M1_ARPROT = 3'b000;
    M1_WDATA = 64'h0; M1_WSTRB = 4'h0;
    {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID} = 5'b0;
    S_BRESP = 3'b000; S_RRESP = 3'b000; S_RDATA = 64'h0;
`ifdef ARB_ROUND_ROBIN_EN
    tie2_exp = 2'b01;
`else
    tie2_exp = 2'b10;
`endif

    // reset state
    tick(); tick();
    ARESETn = 1'b1;
    settle();
    check("rst_grant", GrantOut, 2'b00);
    check("rst_s_valids", {S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY}, 5'b0);
    check("rst_m_readys", {M0_AWREADY, M0_WREADY, M0_ARREADY, M1_AWREADY, M1_WREADY, M1_ARREADY}, 6'b0);

    // M1 write, W presented before AW
    tick();
    M1_WVALID = 1'b1; M1_WDATA = 64'hDEAD_BEEF; M1_WSTRB = 4'hF; S_WREADY = 1'b1;
    settle();
    check("w_early_no_wready", M1_WREADY, 1'b0);
    check("w_early_s_wvalid", S_WVALID, 1'b0);
    tick(); tick();
    M1_AWVALID = 1'b1; M1_AWADDR = 64'h10;
    settle();
    check("w_idle_grant", GrantOut, 2'b00);
    tick();
    settle();
    check("w_grant", GrantOut, 2'b10);
    check("w_s_wvalid", S_WVALID, 1'b1);
    check("w_s_wdata", S_WDATA, 64'hDEAD_BEEF);
    check("w_s_wstrb", S_WSTRB, 4'hF);
    check("w_m1_wready", M1_WREADY, 1'b1);
    check("w_s_awvalid", S_AWVALID, 1'b1);
    tick();
    settle();
    check("w_wvalid_masked", S_WVALID, 1'b0);
    check("w_wready_masked", M1_WREADY, 1'b0);
    check("w_aw_pending", S_AWVALID, 1'b1);
    check("w_no_bresp_yet", M1_BVALID, 1'b0);
    M1_WVALID = 1'b0; S_WREADY = 1'b0;
    tick();
    S_AWREADY = 1'b1;
    settle();
    check("w_s_awaddr", S_AWADDR, 64'h10);
    check("w_m1_awready", M1_AWREADY, 1'b1);
    tick();
    M1_AWVALID = 1'b0; S_AWREADY = 1'b0;
    S_BVALID = 1'b1; S_BRESP = 3'b111; M1_BREADY = 1'b1;
    settle();
    check("w_m1_bvalid", M1_BVALID, 1'b1);
    check("w_m1_bresp", M1_BRESP, 3'b111);
    check("w_s_bready", S_BREADY, 1'b1);
    check("w_m0_bvalid", M0_BVALID, 1'b0);
    tick();
    S_BVALID = 1'b0; S_BRESP = 3'b000; M1_BREADY = 1'b0;
    settle();
    check("w_release", GrantOut, 2'b00);

    // single M0 read with slave ARREADY after 2 cycles
    M0_ARVALID = 1'b1; M0_ARADDR = 64'h8000_0000;
    settle();
    check("r_idle_arvalid", S_ARVALID, 1'b0);
    tick();
    settle();
    check("r_grant", GrantOut, 2'b01);
    check("r_s_arvalid", S_ARVALID, 1'b1);
    check("r_s_araddr", S_ARADDR, 64'h8000_0000);
    check("r_no_arready", M0_ARREADY, 1'b0);
    tick();
    S_ARREADY = 1'b1;
    settle();
    check("r_m0_arready", M0_ARREADY, 1'b1);
    check("r_m1_arready", M1_ARREADY, 1'b0);
    tick();
    M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
    S_RVALID = 1'b1; S_RDATA = 64'h1122334455667788; S_RRESP = 3'b010; M0_RREADY = 1'b1;
    settle();
    check("r_m0_rvalid", M0_RVALID, 1'b1);
    check("r_m0_rdata", M0_RDATA, 64'h1122334455667788);
    check("r_m0_rresp", M0_RRESP, 3'b010);
    check("r_s_rready", S_RREADY, 1'b1);
    check("r_m1_rdata", M1_RDATA, 64'h0);
    check("r_grant_rdata", GrantOut, 2'b01);
    check("r_s_arvalid_off", S_ARVALID, 1'b0);
    tick();
    S_RVALID = 1'b0; M0_RREADY = 1'b0;
    settle();
    check("r_release", GrantOut, 2'b00);
    check("r_m0_rvalid_off", M0_RVALID, 1'b0);

    // same-cycle contention
    M0_ARVALID = 1'b1; M0_ARADDR = 64'h100;
    M1_ARVALID = 1'b1; M1_ARADDR = 64'h200;
    tick();
    S_ARREADY = 1'b1;
    settle();
    check("tie1_grant", GrantOut, 2'b10);
    check("tie1_araddr", S_ARADDR, 64'h200);
    check("tie1_m0_wait", M0_ARREADY, 1'b0);
    finish_read(1);
    M1_ARVALID = 1'b1;
    settle();
    check("tie_idle_gap", GrantOut, 2'b00);
    tick();
    settle();
    check("tie2_grant", GrantOut, tie2_exp);
    check("tie2_araddr", S_ARADDR, (tie2_exp == 2'b01) ? 64'h100 : 64'h200);
    finish_read((tie2_exp == 2'b01) ? 0 : 1);
    tick();
    settle();
    check("tie3_grant", GrantOut, (tie2_exp == 2'b01) ? 2'b10 : 2'b01);
    finish_read((tie2_exp == 2'b01) ? 1 : 0);

    // M0 write and read together: write runs first
    M0_AWVALID = 1'b1; M0_AWADDR = 64'h40; M0_WVALID = 1'b1; M0_WDATA = 64'h55; M0_WSTRB = 4'h3;
    M0_ARVALID = 1'b1; M0_ARADDR = 64'h80;
    tick();
    S_AWREADY = 1'b1; S_WREADY = 1'b1;
    settle();
    check("wr_grant", GrantOut, 2'b01);
    check("wr_s_awvalid", S_AWVALID, 1'b1);
    check("wr_s_arvalid", S_ARVALID, 1'b0);
    check("wr_m0_arready", M0_ARREADY, 1'b0);
    tick();
    M0_AWVALID = 1'b0; M0_WVALID = 1'b0; S_AWREADY = 1'b0; S_WREADY = 1'b0;
    S_BVALID = 1'b1; S_BRESP = 3'b000; M0_BREADY = 1'b1;
    settle();
    check("wr_m0_bvalid", M0_BVALID, 1'b1);
    check("wr_s_arvalid_b", S_ARVALID, 1'b0);
    tick();
    S_BVALID = 1'b0; M0_BREADY = 1'b0;
    settle();
    check("wr_idle_gap", {GrantOut, S_ARVALID}, 3'b000);
    tick();
    settle();
    check("wr_then_read", S_ARVALID, 1'b1);
    check("wr_read_addr", S_ARADDR, 64'h80);
    finish_read(0);

    // read-data backpressure on M1 while M0 waits
    M1_ARVALID = 1'b1; M1_ARADDR = 64'h20;
    tick();
    finish_read(1);
    M1_ARVALID = 1'b1;
    tick();
    S_ARREADY = 1'b1;
    tick();
    M1_ARVALID = 1'b0; S_ARREADY = 1'b0;
    S_RVALID = 1'b1; S_RDATA = 64'hA5; M1_RREADY = 1'b0;
    M0_ARVALID = 1'b1; M0_ARADDR = 64'h300;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_grant", GrantOut, 2'b10);
      check("bp_m0_arready", M0_ARREADY, 1'b0);
      check("bp_s_rready", S_RREADY, 1'b0);
      tick();
    end
    M1_RREADY = 1'b1;
    settle();
    check("bp_m1_rdata", M1_RDATA, 64'hA5);
    tick();
    S_RVALID = 1'b0; M1_RREADY = 1'b0;
    settle();
    check("bp_idle_gap", GrantOut, 2'b00);
    tick();
    settle();
    check("bp_m0_grant", GrantOut, 2'b01);
    check("bp_m0_araddr", S_ARADDR, 64'h300);
    finish_read(0);

    // reset in RDATA drops the transaction
    M0_ARVALID = 1'b1; M0_ARADDR = 64'h8;
    tick();
    S_ARREADY = 1'b1;
    tick();
    M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
    S_RVALID = 1'b1; S_RDATA = 64'hFFFF; M0_RREADY = 1'b0;
    settle();
    check("rs_before", M0_RVALID, 1'b1);
    ARESETn = 1'b0;
    tick();
    settle();
    check("rs_grant", GrantOut, 2'b00);
    check("rs_m0_rvalid", M0_RVALID, 1'b0);
    check("rs_m0_rdata", M0_RDATA, 64'h0);
    check("rs_s_rready", S_RREADY, 1'b0);
    ARESETn = 1'b1;
    tick();
    settle();
    check("rs_after", {GrantOut, M0_RVALID, M1_RVALID}, 4'b0);
    S_RVALID = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
